digit_counter3: RTL and testbench
=================================

DIGIT_COUNTER3 -- requirements
Module: digit_counter3

Interface
REQ-001 The block SHALL have parameter PRESCALE, default 4: the number of RUN-state clock cycles per digit step; legal range 1..65535.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit: synchronous active-high reset.
REQ-004 The block SHALL have port start, input, 1 bit: request to begin or resume counting.
REQ-005 The block SHALL have port stop, input, 1 bit: request to pause counting.
REQ-006 The block SHALL have port clear, input, 1 bit: return the digit to 0 and go idle.
REQ-007 The block SHALL have port load, input, 1 bit: load load_val into the digit.
REQ-008 The block SHALL have port load_val, input, 3 bits: value used by load.
REQ-009 The block SHALL have port dir, input, 1 bit: 1 counts down, 0 counts up; present only when the REQ-027 macro is defined.
REQ-010 The block SHALL have outputs A, B, C, 1 bit each: the registered digit {A,B,C}, with A the MSB, feeding the 3-bit 7-segment decoder directly.
REQ-011 The block SHALL have output tc, 1 bit: one-cycle terminal-count pulse on wrap.
REQ-012 The block SHALL have output running, 1 bit: high while in the RUN state.

Function
REQ-013 The FSM SHALL have states IDLE, RUN and HOLD, with running = (state == RUN).
REQ-014 Control SHALL take effect at a clock edge, applied in priority order rst > clear > load > stop > start.
REQ-015 Clear SHALL set the digit to 0, the prescaler to 0, tc to 0 and the state to IDLE.
REQ-016 Load SHALL set the digit to load_val and the prescaler to 0, leave the state unchanged, produce no tc and suppress any step in that cycle.
REQ-017 Stop SHALL move RUN to HOLD and retain the prescaler value; in IDLE or HOLD it is ignored.
REQ-018 Start SHALL move IDLE to RUN with the prescaler at 0, and move HOLD to RUN with the prescaler retained; in RUN it is ignored.
REQ-019 When start and stop are asserted together, stop SHALL win, so RUN goes to HOLD and IDLE/HOLD remain unchanged.
REQ-020 In RUN the prescaler SHALL increment each cycle; at PRESCALE-1 it returns to 0 and the digit steps by one in the same edge.
REQ-021 With PRESCALE=1, the digit SHALL step on every RUN cycle.
REQ-022 Stepping SHALL wrap modulo 8: up 7 goes to 0 and down 0 goes to 7.
REQ-023 tc SHALL be registered and high for exactly the one cycle in which the wrapped value (0 for up, 7 for down) is first visible on A/B/C; otherwise tc is 0.
REQ-024 The prescaler register SHALL be max(1, ceil(log2(PRESCALE))) bits wide with no overflow past PRESCALE-1.

Reset
REQ-025 When rst is high at a clock edge, the state SHALL become IDLE, {A,B,C} = 000, tc = 0, running = 0 and the prescaler = 0, regardless of any other input.
REQ-026 When rst is asserted mid-count, the block SHALL abandon the count with no tc pulse and restart only on a new start after rst is released.

Configuration
REQ-027 When macro DIGIT_COUNTER3_DOWN_EN is defined, the dir port SHALL exist and select direction per step, sampled at the stepping edge; when undefined, the port SHALL be absent and the block counts up only.
REQ-028 A change of dir while in RUN SHALL affect only the next step and SHALL NOT reset the prescaler.

Verification (PRESCALE=4 unless stated)
REQ-029 Reset, then one start pulse: running=1 from the next cycle and the digit goes 0,1,2 … stepping every 4 cycles; the 8th step gives 7 to 0 with tc=1 for exactly 1 cycle.
REQ-030 In RUN with prescaler=2, pulse stop, wait 10 cycles, pulse start: the digit stays constant throughout HOLD and the next step occurs 2 cycles after resume.
REQ-031 Pulse load with load_val=101 while in RUN, one cycle before a step edge: the digit is 5, with no step and no tc, and the next step to 6 comes 4 cycles later.
REQ-032 Assert start+stop together in IDLE, then clear+load together in RUN: the state stays IDLE, then the digit becomes 0, the state IDLE and tc=0.
REQ-033 With DIGIT_COUNTER3_DOWN_EN defined, load 000, set dir=1, start: the digit goes to 7 after 4 cycles with tc=1, then 6; assert rst mid-count and expect 000, IDLE and no tc.
REQ-034 With PRESCALE=1, start: the digit steps every cycle 0..7 and tc pulses every 8 cycles.

Source files
------------

// File: rtl/digit_counter3.sv
// Single 3-bit digit counter with prescaler, IDLE/RUN/HOLD control and terminal-count pulse.
// Optional down counting via the dir port when DIGIT_COUNTER3_DOWN_EN is defined.
module digit_counter3 #(
  parameter int PRESCALE = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       stop,
  input  logic       clear,
  input  logic       load,
  input  logic [2:0] load_val,
`ifdef DIGIT_COUNTER3_DOWN_EN
  input  logic       dir,
`endif
  output logic       A,
  output logic       B,
  output logic       C,
  output logic       tc,
  output logic       running
);

  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(PRESCALE - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HOLD = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [2:0]      digit_q, digit_d;
  logic [PW-1:0]   presc_q, presc_d;
  logic            tc_q, tc_d;
  logic            running_q;
  logic            down_s;
  logic [2:0]      step_val_s;
  logic            wrap_s;

`ifdef DIGIT_COUNTER3_DOWN_EN
  assign down_s = dir;
`else
  assign down_s = 1'b0;
`endif

  assign step_val_s = down_s ? (digit_q - 3'd1) : (digit_q + 3'd1);
  assign wrap_s     = down_s ? (digit_q == 3'd0) : (digit_q == 3'd7);

  // Next-state selection in priority order clear > load > stop > start > count.
  always_comb begin
    state_d = state_q;
    digit_d = digit_q;
    presc_d = presc_q;
    tc_d    = 1'b0;
    if (clear) begin
      state_d = IDLE;
      digit_d = 3'd0;
      presc_d = '0;
    end else if (load) begin
      digit_d = load_val;
      presc_d = '0;
    end else if (stop) begin
      if (state_q == RUN) begin
        state_d = HOLD;
      end else begin
        state_d = state_q;
      end
    end else if (start && (state_q != RUN)) begin
      // Resuming from HOLD keeps the partial prescaler count.
      if (state_q == IDLE) begin
        presc_d = '0;
      end else begin
        presc_d = presc_q;
      end
      state_d = RUN;
    end else if (state_q == RUN) begin
      if (presc_q == PRESC_LAST) begin
        presc_d = '0;
        digit_d = step_val_s;
        tc_d    = wrap_s;
      end else begin
        presc_d = presc_q + PW'(1);
      end
    end else begin
      state_d = state_q;
    end
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      digit_q   <= 3'd0;
      presc_q   <= '0;
      tc_q      <= 1'b0;
      running_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      digit_q   <= digit_d;
      presc_q   <= presc_d;
      tc_q      <= tc_d;
      running_q <= (state_d == RUN);
    end
  end

  assign {A, B, C} = digit_q;
  assign tc        = tc_q;
  assign running   = running_q;

endmodule

// File: tb/tb_digit_counter3.sv
// Bench for digit_counter3: table vectors, directed corner sequences and a random run
// against an arithmetic reference model, on PRESCALE=4 and PRESCALE=1 instances.
module tb_digit_counter3;

  logic       clk = 1'b0;
  logic       rst, start, stop, clear, load, dir;
  logic [2:0] load_val;
  logic       a4, b4, c4, tc4, run4;
  logic       a1, b1, c1, tc1, run1;

  int passed = 0;
  int total  = 0;

  localparam int S_IDLE = 0;
  localparam int S_RUN  = 1;
  localparam int S_HOLD = 2;

  typedef struct {
    int state;
    int digit;
    int presc;
    int tc;
  } model_t;

  typedef struct {
    logic       rst, start, stop, clear, load;
    logic [2:0] lv;
    int         ed;
    int         etc;
    int         erun;
  } vec_t;

  model_t m4, m1;
  vec_t   vecs[20];

  digit_counter3 #(.PRESCALE(4)) dut (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .clear(clear), .load(load),
    .load_val(load_val),
`ifdef DIGIT_COUNTER3_DOWN_EN
    .dir(dir),
`endif
    .A(a4), .B(b4), .C(c4), .tc(tc4), .running(run4)
  );

  digit_counter3 #(.PRESCALE(1)) dut1 (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .clear(clear), .load(load),
    .load_val(load_val),
`ifdef DIGIT_COUNTER3_DOWN_EN
    .dir(dir),
`endif
    .A(a1), .B(b1), .C(c1), .tc(tc1), .running(run1)
  );

  always #5 clk = ~clk;

  function automatic model_t mstep(model_t m, int ps);
    model_t n;
    int dn;
    n = m;
    n.tc = 0;
`ifdef DIGIT_COUNTER3_DOWN_EN
    dn = int'(dir);
`else
    dn = 0;
`endif
    if (rst) begin
      n.state = S_IDLE; n.digit = 0; n.presc = 0;
    end else if (clear) begin
      n.state = S_IDLE; n.digit = 0; n.presc = 0;
    end else if (load) begin
      n.digit = int'(load_val); n.presc = 0;
    end else if (stop) begin
      if (m.state == S_RUN) n.state = S_HOLD;
    end else if (start && m.state != S_RUN) begin
      if (m.state == S_IDLE) n.presc = 0;
      n.state = S_RUN;
    end else if (m.state == S_RUN) begin
      n.presc = (m.presc + 1) % ps;
      if (n.presc == 0) begin
        n.digit = (dn != 0) ? (m.digit + 7) % 8 : (m.digit + 1) % 8;
        n.tc    = (n.digit == ((dn != 0) ? 7 : 0)) ? 1 : 0;
      end
    end
    return n;
  endfunction

  task automatic check(string name, int act, int exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
  endtask

  task automatic tick(string name);
    @(posedge clk);
    m4 = mstep(m4, 4);
    m1 = mstep(m1, 1);
    #1;
    check({name, " p4 digit"}, int'({a4, b4, c4}), m4.digit);
    check({name, " p4 tc"}, int'(tc4), m4.tc);
    check({name, " p4 running"}, int'(run4), (m4.state == S_RUN) ? 1 : 0);
    check({name, " p1 digit"}, int'({a1, b1, c1}), m1.digit);
    check({name, " p1 tc"}, int'(tc1), m1.tc);
    check({name, " p1 running"}, int'(run1), (m1.state == S_RUN) ? 1 : 0);
  endtask

  task automatic quiet();
    rst = 1'b0; start = 1'b0; stop = 1'b0; clear = 1'b0; load = 1'b0; load_val = 3'd0;
  endtask

  task automatic do_reset();
    quiet();
    rst = 1'b1;
    tick("reset");
    rst = 1'b0;
  endtask

  initial begin
    // rst start stop clear load lv | digit tc running (PRESCALE=4)
    vecs[0]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 0, 0, 0};
    vecs[1]  = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 3'd0, 0, 0, 0};
    vecs[2]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 0, 0, 1};
    vecs[3]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 0, 0, 1};
    vecs[4]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 0, 0, 1};
    vecs[5]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 0, 0, 1};
    vecs[6]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 1, 0, 1};
    vecs[7]  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 3'd0, 1, 0, 0};
    vecs[8]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 1, 0, 1};
    vecs[9]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 3'd5, 5, 0, 1};
    vecs[10] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 5, 0, 1};
    vecs[11] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 3'd3, 0, 0, 0};
    vecs[12] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 3'd7, 7, 0, 0};
    vecs[13] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 7, 0, 1};
    vecs[14] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 7, 0, 1};
    vecs[15] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 7, 0, 1};
    vecs[16] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 7, 0, 1};
    vecs[17] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 0, 1, 1};
    vecs[18] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 0, 0, 1};
    vecs[19] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 0, 0, 0};

    m4 = '{0, 0, 0, 0};
    m1 = '{0, 0, 0, 0};
    dir = 1'b0;
    quiet();

    for (int i = 0; i < 20; i++) begin
      rst = vecs[i].rst; start = vecs[i].start; stop = vecs[i].stop;
      clear = vecs[i].clear; load = vecs[i].load; load_val = vecs[i].lv;
      tick("table");
      check($sformatf("tbl%0d digit", i), int'({a4, b4, c4}), vecs[i].ed);
      check($sformatf("tbl%0d tc", i), int'(tc4), vecs[i].etc);
      check($sformatf("tbl%0d running", i), int'(run4), vecs[i].erun);
    end

    // Full up cycle on both instances: tc only on the wrap to 0.
    do_reset();
    start = 1'b1;
    tick("seq29 start");
    start = 1'b0;
    check("seq29 running", int'(run4), 1);
    for (int k = 1; k <= 32; k++) begin
      tick("seq29");
      check($sformatf("seq29 k%0d digit", k), int'({a4, b4, c4}), (k / 4) % 8);
      check($sformatf("seq29 k%0d tc", k), int'(tc4), (k == 32) ? 1 : 0);
      check($sformatf("seq34 k%0d digit", k), int'({a1, b1, c1}), k % 8);
      check($sformatf("seq34 k%0d tc", k), int'(tc1), (k % 8 == 0) ? 1 : 0);
    end

    // Pause with prescaler at 2, resume: step two cycles after resume.
    do_reset();
    start = 1'b1; tick("seq30 start"); start = 1'b0;
    tick("seq30"); tick("seq30");
    stop = 1'b1; tick("seq30 stop"); stop = 1'b0;
    for (int k = 0; k < 10; k++) begin
      tick("seq30 hold");
      check("seq30 hold digit", int'({a4, b4, c4}), 0);
      check("seq30 hold running", int'(run4), 0);
    end
    start = 1'b1; tick("seq30 resume"); start = 1'b0;
    tick("seq30");
    check("seq30 pre-step digit", int'({a4, b4, c4}), 0);
    tick("seq30");
    check("seq30 step digit", int'({a4, b4, c4}), 1);

    // Load one cycle before a step edge suppresses the step.
    do_reset();
    start = 1'b1; tick("seq31 start"); start = 1'b0;
    tick("seq31"); tick("seq31"); tick("seq31");
    load = 1'b1; load_val = 3'd5; tick("seq31 load"); load = 1'b0;
    check("seq31 load digit", int'({a4, b4, c4}), 5);
    check("seq31 load tc", int'(tc4), 0);
    for (int k = 1; k <= 4; k++) begin
      tick("seq31");
      check($sformatf("seq31 k%0d digit", k), int'({a4, b4, c4}), (k == 4) ? 6 : 5);
    end

`ifdef DIGIT_COUNTER3_DOWN_EN
    // Down count from 0 wraps to 7 with tc; reset mid-count abandons it.
    do_reset();
    load = 1'b1; load_val = 3'd0; tick("seq33 load"); load = 1'b0;
    dir = 1'b1;
    start = 1'b1; tick("seq33 start"); start = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      tick("seq33");
      if (k == 4) begin
        check("seq33 wrap digit", int'({a4, b4, c4}), 7);
        check("seq33 wrap tc", int'(tc4), 1);
      end
    end
    check("seq33 next digit", int'({a4, b4, c4}), 6);
    tick("seq33"); tick("seq33");
    rst = 1'b1; tick("seq33 rst"); rst = 1'b0;
    check("seq33 rst digit", int'({a4, b4, c4}), 0);
    check("seq33 rst running", int'(run4), 0);
    check("seq33 rst tc", int'(tc4), 0);
    dir = 1'b0;
`endif

    // Random control traffic against the reference model.
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      rst      = ($urandom_range(199) == 0);
      clear    = ($urandom_range(99) == 0);
      load     = ($urandom_range(29) == 0);
      stop     = ($urandom_range(39) == 0);
      start    = ($urandom_range(7) == 0);
      load_val = 3'($urandom_range(7));
`ifdef DIGIT_COUNTER3_DOWN_EN
      if ($urandom_range(15) == 0) dir = ~dir;
`endif
      tick("rnd");
    end
    quiet();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
